decode_stage: RTL and testbench
===============================

# decode_stage

Instruction decode stage of the RV32I core, directly downstream of the instruction fetch memory. It pairs the fetched word with its PC and decodes register indices, the sign-extended immediate and control signals. Results are held in a registered IF/ID-style output bank with stall and flush control for the execute stage. Fetch returns `data_out` one clock after the PC is presented, so this block delays the PC and valid by one cycle internally to realign them.

## Interface

- `RESET_PC`, default 32'h0000_0000: value of `pc_out` after reset.
- `clk`, input, 1: single clock; all state updates on rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `pc_in`, input, 32: PC presented to fetch in this cycle.
- `pc_valid`, input, 1: `pc_in` is a real fetch request.
- `instr_in`, input, 32: fetch `data_out`, corresponding to the previous cycle's `pc_in`.
- `stall`, input, 1: hold all state; downstream is not accepting.
- `flush`, input, 1: kill both in-flight slots (taken branch or jump).
- `out_valid`, output, 1: decoded bundle is valid.
- `pc_out`, output, 32: PC of the decoded instruction.
- `rs1_addr`, `rs2_addr`, `rd_addr`, output, 5 each: register indices.
- `imm`, output, 32: sign-extended immediate.
- `funct3`, output, 3: raw funct3, used for branch, load and store sizing.
- `alu_op`, output, 4: ALU operation code (encoding below).
- `alu_src_imm`, output, 1: ALU operand B comes from `imm`.
- `alu_src_pc`, output, 1: ALU operand A comes from `pc_out` (AUIPC, JAL, JALR link).
- `reg_write`, `mem_read`, `mem_write`, `branch`, `jump`, output, 1 each: control flags.
- `illegal`, output, 1: unrecognised opcode or funct field.

## Operation

**Align slot.** `pc_d1` and `v_d1` are registered copies of `pc_in` and `pc_valid`.
- Updated every non-stalled cycle.
- On `flush`, `v_d1` is cleared.

**Decode.** Combinational, from `instr_in` and `pc_d1`.

Immediate formats (all sign-extended from bit 31):
- I: `instr[31:20]`.
- S: `{instr[31:25], instr[11:7]}`.
- B: `{instr[31], instr[7], instr[30:25], instr[11:8], 0}`.
- U: `{instr[31:12], 12'b0}`.
- J: `{instr[31], instr[19:12], instr[20], instr[30:21], 0}`.

`alu_op` encoding:
- 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB.

Opcode map:
- OP (0110011): `funct7[5]` selects SUB or SRA; any other `funct7` is illegal.
- OP-IMM (0010011): SLLI and SRLI require `funct7` = 0; SRAI requires `funct7` = 0100000.
- LOAD (0000011): ADD, `mem_read`, `reg_write`, I-imm.
- STORE (0100011): ADD, `mem_write`, S-imm.
- BRANCH (1100011): `branch`, B-imm, `alu_op` SUB.
- JAL (1101111): `jump`, `reg_write`, J-imm, `alu_src_pc`.
- JALR (1100111): `jump`, `reg_write`, I-imm.
- LUI (0110111): PASSB, U-imm.
- AUIPC (0010111): ADD, `alu_src_pc`, U-imm.
- FENCE and SYSTEM: NOP, with all write and memory flags at 0.
- Any other opcode sets `illegal`.
- When `illegal` = 1: `reg_write`, `mem_read`, `mem_write`, `branch` and `jump` are forced to 0.
- When `rd` = 0, `reg_write` is forced to 0.

**Output bank.** Each cycle, in priority order:
- `flush` = 1: `out_valid` <= 0; `pc_d1` and `v_d1` still load the new `pc_in`, but `v_d1` is cleared.
- `stall` = 1 and no flush: all registers hold.
- Otherwise: the output bank loads the decode result and `out_valid` <= `v_d1`.

## Timing

- **Reset** (asynchronous, `rst` = 0):
  - `v_d1` = 0, `out_valid` = 0, `pc_d1` = `pc_out` = `RESET_PC`.
  - All other outputs are 0, `alu_op` = ADD.
  - Released synchronously at the next edge.
- **Latency:** the PC presented at edge N appears on `pc_out` with `out_valid` = 1 after edge N+2, at a throughput of 1 per cycle.
- **Stall:** the upstream PC generator holds `pc_in` while `stall` = 1. Fetch re-reads the same word, so the realigned instruction is unchanged when the stall releases. Output values are stable for every stalled cycle.
- **Flush and stall in the same cycle:** flush wins.
- **Reset mid-operation:** outputs go to their reset values immediately, without waiting for a clock edge.
- **Bubbles:** `out_valid` = 0 whenever `v_d1` was 0. Decoded fields are don't-care in that case, but they still update.

## Test plan

- **Reset:** assert `rst` = 0 mid-stream. `out_valid` drops to 0 within the same cycle and `pc_out` = `RESET_PC`. After release, the first valid output arrives 2 edges after the first `pc_valid`.
- **ADDI:** `instr` 0x00500093 at pc 0x4 gives `rd` = 1, `rs1` = 0, `imm` = 5, ADD, `alu_src_imm`, `reg_write`, `pc_out` = 0x4.
- **SW and BEQ:**
  - 0x0020A423 gives `rs1` = 1, `rs2` = 2, `imm` = 8, `mem_write` = 1, `reg_write` = 0.
  - 0xFE000EE3 gives `branch` = 1, `imm` = 0xFFFFFFFC.
- **LUI, SUB and illegal:**
  - 0x123452B7 gives `imm` = 0x12345000, PASSB, `rd` = 5.
  - 0x402081B3 gives `alu_op` = SUB.
  - 0x00000000 gives `illegal` = 1 with all control flags 0.
- **Stall:** assert `stall` for 3 cycles with `pc_in` held. The outputs are identical in every stalled cycle. After release, the sequence continues with no instruction lost or duplicated.
- **Flush:** assert `flush` for 1 cycle while two valid instructions are in flight. The next two `out_valid` samples are 0. The redirected PC presented during the flush cycle appears with `out_valid` = 1 two edges later.

Source files
------------

// File: rtl/decode_stage_if.sv
// Fetch-to-decode bus: fetch request/data and pipeline control in, decoded bundle out.
interface decode_stage_if;
    logic [31:0] pc_in;
    logic        pc_valid;
    logic [31:0] instr_in;
    logic        stall;
    logic        flush;

    logic        out_valid;
    logic [31:0] pc_out;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [31:0] imm;
    logic [2:0]  funct3;
    logic [3:0]  alu_op;
    logic        alu_src_imm;
    logic        alu_src_pc;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        illegal;

    modport master (
        output pc_in, pc_valid, instr_in, stall, flush,
        input  out_valid, pc_out, rs1_addr, rs2_addr, rd_addr, imm, funct3, alu_op,
               alu_src_imm, alu_src_pc, reg_write, mem_read, mem_write, branch, jump, illegal
    );

    modport slave (
        input  pc_in, pc_valid, instr_in, stall, flush,
        output out_valid, pc_out, rs1_addr, rs2_addr, rd_addr, imm, funct3, alu_op,
               alu_src_imm, alu_src_pc, reg_write, mem_read, mem_write, branch, jump, illegal
    );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: realigns PC with the fetched word, decodes it and registers the
// result in an IF/ID-style output bank with stall and flush control.
module decode_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic            clk,
    input logic            rst,
    decode_stage_if.slave  bus
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Base ALU operation for funct3; the SUB/SRA variants are selected by funct7.
    function automatic logic [3:0] f3_alu(input logic [2:0] f3);
        logic [3:0] op;
        unique case (f3)
            3'b000:  op = ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    // Align slot: PC/valid delayed one cycle to meet the fetched word.
    logic [31:0] pc_d1_q;
    logic        v_d1_q;

    // Registered output bank.
    logic        out_valid_q;
    logic [31:0] pc_out_q;
    logic [4:0]  rs1_q, rs2_q, rd_q;
    logic [31:0] imm_q;
    logic [2:0]  funct3_q;
    logic [3:0]  alu_op_q;
    logic        src_imm_q, src_pc_q;
    logic        reg_write_q, mem_read_q, mem_write_q, branch_q, jump_q, illegal_q;

    // Combinational decode results.
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] dec_imm;
    logic [3:0]  dec_alu;
    logic        dec_src_imm, dec_src_pc;
    logic        dec_rw, dec_mr, dec_mw, dec_br, dec_jp, dec_ill;

    assign instr  = bus.instr_in;
    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // Opcode decode into immediate, ALU control and pipeline flags.
    always_comb begin
        dec_imm     = '0;
        dec_alu     = ALU_ADD;
        dec_src_imm = 1'b0;
        dec_src_pc  = 1'b0;
        dec_rw      = 1'b0;
        dec_mr      = 1'b0;
        dec_mw      = 1'b0;
        dec_br      = 1'b0;
        dec_jp      = 1'b0;
        dec_ill     = 1'b0;

        case (opcode)
            OPC_OP: begin
                dec_rw = 1'b1;
                if (f7 == F7_ZERO) begin
                    dec_alu = f3_alu(f3);
                end else if (f7 == F7_ALT && f3 == 3'b000) begin
                    dec_alu = ALU_SUB;
                end else if (f7 == F7_ALT && f3 == 3'b101) begin
                    dec_alu = ALU_SRA;
                end else begin
                    dec_ill = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                dec_rw      = 1'b1;
                dec_src_imm = 1'b1;
                dec_imm     = imm_i;
                dec_alu     = f3_alu(f3);
                if (f3 == 3'b001 && f7 != F7_ZERO) begin
                    dec_ill = 1'b1;
                end else if (f3 == 3'b101) begin
                    if (f7 == F7_ALT) begin
                        dec_alu = ALU_SRA;
                    end else if (f7 != F7_ZERO) begin
                        dec_ill = 1'b1;
                    end
                end
            end
            OPC_LOAD: begin
                dec_mr      = 1'b1;
                dec_rw      = 1'b1;
                dec_src_imm = 1'b1;
                dec_imm     = imm_i;
            end
            OPC_STORE: begin
                dec_mw      = 1'b1;
                dec_src_imm = 1'b1;
                dec_imm     = imm_s;
            end
            OPC_BRANCH: begin
                dec_br  = 1'b1;
                dec_alu = ALU_SUB;
                dec_imm = imm_b;
            end
            OPC_JAL: begin
                dec_jp     = 1'b1;
                dec_rw     = 1'b1;
                dec_src_pc = 1'b1;
                dec_imm    = imm_j;
            end
            OPC_JALR: begin
                // Operand A is the PC so the ALU forms the link value.
                dec_jp     = 1'b1;
                dec_rw     = 1'b1;
                dec_src_pc = 1'b1;
                dec_imm    = imm_i;
            end
            OPC_LUI: begin
                dec_rw      = 1'b1;
                dec_alu     = ALU_PASSB;
                dec_src_imm = 1'b1;
                dec_imm     = imm_u;
            end
            OPC_AUIPC: begin
                dec_rw      = 1'b1;
                dec_src_imm = 1'b1;
                dec_src_pc  = 1'b1;
                dec_imm     = imm_u;
            end
            OPC_FENCE, OPC_SYSTEM: begin
                // Treated as a NOP.
            end
            default: dec_ill = 1'b1;
        endcase

        // An illegal word must not produce any architectural side effect.
        if (dec_ill) begin
            dec_imm     = '0;
            dec_alu     = ALU_ADD;
            dec_src_imm = 1'b0;
            dec_src_pc  = 1'b0;
            dec_rw      = 1'b0;
            dec_mr      = 1'b0;
            dec_mw      = 1'b0;
            dec_br      = 1'b0;
            dec_jp      = 1'b0;
        end
        if (instr[11:7] == 5'd0) begin
            dec_rw = 1'b0;
        end
    end

    // Align slot register: flush kills the slot, stall holds it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_d1_q <= RESET_PC;
            v_d1_q  <= 1'b0;
        end else if (bus.flush) begin
            pc_d1_q <= bus.pc_in;
            v_d1_q  <= 1'b0;
        end else if (!bus.stall) begin
            pc_d1_q <= bus.pc_in;
            v_d1_q  <= bus.pc_valid;
        end
    end

    // Output bank: loads on flush (as a bubble) or when not stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            pc_out_q    <= RESET_PC;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            imm_q       <= '0;
            funct3_q    <= '0;
            alu_op_q    <= ALU_ADD;
            src_imm_q   <= 1'b0;
            src_pc_q    <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            branch_q    <= 1'b0;
            jump_q      <= 1'b0;
            illegal_q   <= 1'b0;
        end else if (bus.flush || !bus.stall) begin
            out_valid_q <= v_d1_q && !bus.flush;
            pc_out_q    <= pc_d1_q;
            rs1_q       <= instr[19:15];
            rs2_q       <= instr[24:20];
            rd_q        <= instr[11:7];
            imm_q       <= dec_imm;
            funct3_q    <= f3;
            alu_op_q    <= dec_alu;
            src_imm_q   <= dec_src_imm;
            src_pc_q    <= dec_src_pc;
            reg_write_q <= dec_rw;
            mem_read_q  <= dec_mr;
            mem_write_q <= dec_mw;
            branch_q    <= dec_br;
            jump_q      <= dec_jp;
            illegal_q   <= dec_ill;
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.pc_out      = pc_out_q;
    assign bus.rs1_addr    = rs1_q;
    assign bus.rs2_addr    = rs2_q;
    assign bus.rd_addr     = rd_q;
    assign bus.imm         = imm_q;
    assign bus.funct3      = funct3_q;
    assign bus.alu_op      = alu_op_q;
    assign bus.alu_src_imm = src_imm_q;
    assign bus.alu_src_pc  = src_pc_q;
    assign bus.reg_write   = reg_write_q;
    assign bus.mem_read    = mem_read_q;
    assign bus.mem_write   = mem_write_q;
    assign bus.branch      = branch_q;
    assign bus.jump        = jump_q;
    assign bus.illegal     = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed test-plan steps followed by randomized traffic,
// checked against a behavioural pipeline/decode model.
module tb_decode_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0080;

    logic clk;
    logic rst;

    decode_stage_if dif ();

    decode_stage #(.RESET_PC(RST_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory model, addressed by the PC the decode slot is holding.
    logic [31:0] imem [64];
    logic [31:0] s_pc;
    logic        s_v;
    logic        exp_ov;
    logic [31:0] exp_pc;
    logic [31:0] exp_w;

    assign dif.instr_in = imem[s_pc[7:2]];

    int n_pass;
    int n_total;

    typedef struct packed {
        logic [31:0] imm;
        logic [3:0]  alu;
        logic        src_imm;
        logic        src_pc;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        br;
        logic        jp;
        logic        ill;
    } dec_t;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference decode built straight from the instruction-set rules.
    function automatic dec_t ref_dec(input logic [31:0] w);
        dec_t d;
        int   base [8];
        int   i_imm, s_imm, b_imm, j_imm;
        logic [6:0] f7;
        logic [2:0] f3;
        base = '{0, 2, 3, 4, 5, 6, 8, 9};
        f7 = w[31:25];
        f3 = w[14:12];
        i_imm = $signed(w) >>> 20;
        s_imm = ($signed(w) >>> 25) * 32 + int'(w[11:7]);
        b_imm = (w[31] ? -4096 : 0) + int'(w[7]) * 2048 + int'(w[30:25]) * 32
              + int'(w[11:8]) * 2;
        j_imm = (w[31] ? -1048576 : 0) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048
              + int'(w[30:21]) * 2;
        d = '0;
        case (w[6:0])
            7'h33: begin
                if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) begin
                    d.alu = 4'(base[f3] + (f7 == 7'h20 ? 1 : 0));
                    d.rw  = 1'b1;
                end else begin
                    d.ill = 1'b1;
                end
            end
            7'h13: begin
                if ((f3 == 3'd1 && f7 != 7'h00) ||
                    (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20)) begin
                    d.ill = 1'b1;
                end else begin
                    d.alu = 4'(base[f3] + ((f3 == 3'd5 && f7 == 7'h20) ? 1 : 0));
                    d.rw = 1'b1; d.src_imm = 1'b1; d.imm = i_imm;
                end
            end
            7'h03: begin d.mr = 1'b1; d.rw = 1'b1; d.src_imm = 1'b1; d.imm = i_imm; end
            7'h23: begin d.mw = 1'b1; d.src_imm = 1'b1; d.imm = s_imm; end
            7'h63: begin d.br = 1'b1; d.alu = 4'd1; d.imm = b_imm; end
            7'h6F: begin d.jp = 1'b1; d.rw = 1'b1; d.src_pc = 1'b1; d.imm = j_imm; end
            7'h67: begin d.jp = 1'b1; d.rw = 1'b1; d.src_pc = 1'b1; d.imm = i_imm; end
            7'h37: begin d.rw = 1'b1; d.alu = 4'd10; d.src_imm = 1'b1; d.imm = w & 32'hFFFFF000; end
            7'h17: begin
                d.rw = 1'b1; d.src_imm = 1'b1; d.src_pc = 1'b1; d.imm = w & 32'hFFFFF000;
            end
            7'h0F, 7'h73: ;
            default: d.ill = 1'b1;
        endcase
        if (w[11:7] == 5'd0) d.rw = 1'b0;
        return d;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [11];
        logic [31:0] w;
        int k;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h0F, 7'h73};
        w = $urandom;
        k = $urandom_range(0, 12);
        if (k < 11) begin
            w[6:0] = ops[k];
            if (k < 2) begin
                case ($urandom_range(0, 2))
                    0: w[31:25] = 7'h00;
                    1: w[31:25] = 7'h20;
                    default: ;
                endcase
            end
        end
        return w;
    endfunction

    task automatic check_reset(input string tag);
        chk({tag, "_out_valid"}, 32'(dif.out_valid), 32'd0);
        chk({tag, "_pc_out"}, dif.pc_out, RST_PC);
        chk({tag, "_rs1"}, 32'(dif.rs1_addr), 32'd0);
        chk({tag, "_rs2"}, 32'(dif.rs2_addr), 32'd0);
        chk({tag, "_rd"}, 32'(dif.rd_addr), 32'd0);
        chk({tag, "_imm"}, dif.imm, 32'd0);
        chk({tag, "_funct3"}, 32'(dif.funct3), 32'd0);
        chk({tag, "_alu_op"}, 32'(dif.alu_op), 32'd0);
        chk({tag, "_ctrl"}, 32'({dif.alu_src_imm, dif.alu_src_pc, dif.reg_write, dif.mem_read,
                                 dif.mem_write, dif.branch, dif.jump, dif.illegal}), 32'd0);
    endtask

    task automatic model_reset();
        s_pc = RST_PC;
        s_v = 1'b0;
        exp_ov = 1'b0;
        exp_pc = RST_PC;
        exp_w = '0;
    endtask

    task automatic check_outputs();
        dec_t d;
        chk("out_valid", 32'(dif.out_valid), 32'(exp_ov));
        if (exp_ov) begin
            d = ref_dec(exp_w);
            chk("pc_out", dif.pc_out, exp_pc);
            chk("rs1", 32'(dif.rs1_addr), 32'(exp_w[19:15]));
            chk("rs2", 32'(dif.rs2_addr), 32'(exp_w[24:20]));
            chk("rd", 32'(dif.rd_addr), 32'(exp_w[11:7]));
            chk("funct3", 32'(dif.funct3), 32'(exp_w[14:12]));
            chk("imm", dif.imm, d.imm);
            chk("alu_op", 32'(dif.alu_op), 32'(d.alu));
            chk("ctrl", 32'({dif.alu_src_imm, dif.alu_src_pc, dif.reg_write, dif.mem_read,
                             dif.mem_write, dif.branch, dif.jump, dif.illegal}),
                32'({d.src_imm, d.src_pc, d.rw, d.mr, d.mw, d.br, d.jp, d.ill}));
        end
    endtask

    // One clock: drive at negedge, advance the model after the edge, check at next negedge.
    task automatic tick(input logic [31:0] pc, input logic v, input logic st, input logic fl);
        dif.pc_in = pc;
        dif.pc_valid = v;
        dif.stall = st;
        dif.flush = fl;
        @(posedge clk);
        #1;
        if (fl) begin
            exp_ov = 1'b0;
            s_pc = pc;
            s_v = 1'b0;
        end else if (!st) begin
            exp_ov = s_v;
            exp_pc = s_pc;
            exp_w = imem[s_pc[7:2]];
            s_pc = pc;
            s_v = v;
        end
        @(negedge clk);
        check_outputs();
    endtask

    logic [31:0] snap_pc, snap_imm;
    logic        snap_ov;
    logic [31:0] cur_pc;
    logic        cur_v;

    initial begin
        n_pass = 0;
        n_total = 0;
        for (int i = 0; i < 64; i++) imem[i] = rand_instr();
        imem[1] = 32'h00500093;
        imem[2] = 32'h0020A423;
        imem[3] = 32'hFE000EE3;
        imem[4] = 32'h123452B7;
        imem[5] = 32'h402081B3;
        imem[6] = 32'h00000000;
        model_reset();
        dif.pc_in = '0;
        dif.pc_valid = 1'b0;
        dif.stall = 1'b0;
        dif.flush = 1'b0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #2 check_reset("por");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Directed decode steps.
        tick(32'h04, 1'b1, 1'b0, 1'b0);
        tick(32'h08, 1'b1, 1'b0, 1'b0);
        chk("addi_valid", 32'(dif.out_valid), 32'd1);
        chk("addi_pc", dif.pc_out, 32'h4);
        chk("addi_rd", 32'(dif.rd_addr), 32'd1);
        chk("addi_imm", dif.imm, 32'd5);
        chk("addi_rw", 32'(dif.reg_write & dif.alu_src_imm), 32'd1);
        tick(32'h0C, 1'b1, 1'b0, 1'b0);
        chk("sw_imm", dif.imm, 32'd8);
        chk("sw_flags", 32'({dif.mem_write, dif.reg_write}), 32'b10);
        tick(32'h10, 1'b1, 1'b0, 1'b0);
        chk("beq_branch", 32'(dif.branch), 32'd1);
        chk("beq_imm", dif.imm, 32'hFFFFFFFC);
        tick(32'h14, 1'b1, 1'b0, 1'b0);
        chk("lui_imm", dif.imm, 32'h12345000);
        chk("lui_alu", 32'(dif.alu_op), 32'd10);
        chk("lui_rd", 32'(dif.rd_addr), 32'd5);
        tick(32'h18, 1'b1, 1'b0, 1'b0);
        chk("sub_alu", 32'(dif.alu_op), 32'd1);
        tick(32'h1C, 1'b1, 1'b0, 1'b0);
        chk("ill_flag", 32'(dif.illegal), 32'd1);
        chk("ill_ctrl", 32'({dif.reg_write, dif.mem_read, dif.mem_write, dif.branch, dif.jump}),
            32'd0);

        // Stall for three cycles with the PC held.
        tick(32'h20, 1'b1, 1'b0, 1'b0);
        tick(32'h24, 1'b1, 1'b1, 1'b0);
        snap_pc = dif.pc_out;
        snap_imm = dif.imm;
        snap_ov = dif.out_valid;
        for (int i = 0; i < 2; i++) begin
            tick(32'h24, 1'b1, 1'b1, 1'b0);
            chk("stall_pc", dif.pc_out, snap_pc);
            chk("stall_imm", dif.imm, snap_imm);
            chk("stall_ov", 32'(dif.out_valid), 32'(snap_ov));
        end
        tick(32'h24, 1'b1, 1'b0, 1'b0);
        chk("unstall_pc0", dif.pc_out, 32'h20);
        tick(32'h28, 1'b1, 1'b0, 1'b0);
        chk("unstall_pc1", dif.pc_out, 32'h24);

        // Flush with two instructions in flight; flush also beats a stall.
        tick(32'h2C, 1'b1, 1'b0, 1'b0);
        tick(32'h60, 1'b1, 1'b1, 1'b1);
        chk("flush_ov0", 32'(dif.out_valid), 32'd0);
        tick(32'h60, 1'b1, 1'b0, 1'b0);
        chk("flush_ov1", 32'(dif.out_valid), 32'd0);
        tick(32'h64, 1'b1, 1'b0, 1'b0);
        chk("redirect_ov", 32'(dif.out_valid), 32'd1);
        chk("redirect_pc", dif.pc_out, 32'h60);

        // Asynchronous reset mid-stream.
        tick(32'h68, 1'b1, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1 check_reset("mid");
        model_reset();
        dif.pc_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick(32'h30, 1'b1, 1'b0, 1'b0);
        chk("post_rst_ov0", 32'(dif.out_valid), 32'd0);
        tick(32'h34, 1'b1, 1'b0, 1'b0);
        chk("post_rst_pc", dif.pc_out, 32'h30);

        // Randomized traffic; upstream holds its PC while stalled.
        cur_pc = 32'h38;
        cur_v = 1'b1;
        for (int i = 0; i < 400; i++) begin
            logic st, fl;
            st = ($urandom_range(0, 99) < 20);
            fl = ($urandom_range(0, 99) < 8);
            if (!st || fl) begin
                cur_pc = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
                cur_v = ($urandom_range(0, 99) < 80);
            end
            tick(cur_pc, cur_v, st, fl);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
